// File: rtl/pe_tile_pkg.sv
// Shared definitions for the parametrised CGRA PE tile: config features, opcodes,
// switch-box source encoding and the config command struct.
package pe_tile_pkg;

  localparam logic [7:0] FEAT_SB  = 8'd0;
  localparam logic [7:0] FEAT_CB0 = 8'd1;
  localparam logic [7:0] FEAT_CB1 = 8'd2;
  localparam logic [7:0] FEAT_PE  = 8'd3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_MAC  = 3'd6,
    OP_PASS = 3'd7
  } pe_op_e;

  // Selects 0..2 walk the other three sides in ascending order; 3 is the PE.
  localparam logic [1:0] SB_SRC_PE = 2'd3;

  typedef struct packed {
    logic        hit;
    logic        wr;
    logic        rd;
    logic [7:0]  feat;
    logic [7:0]  idx;
    logic [31:0] data;
  } cfg_req_t;

  function automatic logic [1:0] sb_src_side(input logic [1:0] own, input logic [1:0] sel);
    return (sel < own) ? sel : sel + 2'd1;
  endfunction

endpackage

// File: rtl/pe_tile_generic_sb_cell.sv
// One switch-box output: 4:1 source mux with an optional output register.
module sb_track_cell #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0][WIDTH-1:0] src,
  input  logic [1:0]            sel,
  input  logic                  reg_en,
  output logic [WIDTH-1:0]      out
);

  logic [WIDTH-1:0] mux, q;

  assign mux = src[sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= mux;
  end

  assign out = reg_en ? q : mux;

endmodule

// File: rtl/pe_tile_generic.sv
// CGRA PE tile: config decode with read-back, two connect boxes, ALU/MAC PE and a
// four-sided switch box built from sb_track_cell instances.
module pe_tile_generic
  import pe_tile_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_TRACKS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   tile_id,
  input  logic [31:0]                   config_addr,
  input  logic [31:0]                   config_data,
  input  logic                          config_valid,
  input  logic                          config_read,
  output logic [31:0]                   config_rd_data,
  output logic                          config_rd_valid,
  input  logic [4*NUM_TRACKS*WIDTH-1:0] in_wires,
  output logic [4*NUM_TRACKS*WIDTH-1:0] out_wires
);

  localparam int NW   = 4 * NUM_TRACKS;
  localparam int SELW = $clog2(NW);

  logic [NW-1:0][WIDTH-1:0] in_w, out_w;
  assign in_w      = in_wires;
  assign out_wires = out_w;

  cfg_req_t req;
  always_comb begin
    req.hit  = config_valid && (config_addr[15:0] == tile_id);
    req.wr   = req.hit && !config_read;
    req.rd   = req.hit && config_read;
    req.feat = config_addr[23:16];
    req.idx  = config_addr[31:24];
    req.data = config_data;
  end

  logic            sb_idx_ok;
  logic [SELW-1:0] sb_idx;
  logic            wr_sb, wr_cb0, wr_cb1, wr_pe, acc_clr;

  assign sb_idx_ok = int'(req.idx) < NW;
  assign sb_idx    = req.idx[SELW-1:0];
  assign wr_sb     = req.wr && (req.feat == FEAT_SB) && sb_idx_ok;
  assign wr_cb0    = req.wr && (req.feat == FEAT_CB0) && (req.idx == 8'd0);
  assign wr_cb1    = req.wr && (req.feat == FEAT_CB1) && (req.idx == 8'd0);
  assign wr_pe     = req.wr && (req.feat == FEAT_PE)  && (req.idx == 8'd0);
  assign acc_clr   = req.wr && (req.feat == FEAT_PE)  && (req.idx == 8'd1);

  logic [NW-1:0][2:0] sb_cfg;
  logic [SELW-1:0]    cb0_sel, cb1_sel;
  pe_op_e             pe_op;
  logic               pe_oreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_cfg  <= '0;
      cb0_sel <= '0;
      cb1_sel <= '0;
      pe_op   <= OP_ADD;
      pe_oreg <= 1'b0;
    end else begin
      if (wr_sb)  sb_cfg[sb_idx] <= req.data[2:0];
      if (wr_cb0) cb0_sel <= req.data[SELW-1:0];
      if (wr_cb1) cb1_sel <= req.data[SELW-1:0];
      if (wr_pe) begin
        pe_op   <= pe_op_e'(req.data[2:0]);
        pe_oreg <= req.data[3];
      end
    end
  end

  logic unused_data;
  assign unused_data = ^req.data[31:4];

  // Invalid addresses fall through to zero; non-hit cycles also drive zero so
  // read buses of all tiles can be OR-reduced.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    case (req.feat)
      FEAT_SB:  if (sb_idx_ok)          rd_word = 32'(sb_cfg[sb_idx]);
      FEAT_CB0: if (req.idx == 8'd0)    rd_word = 32'(cb0_sel);
      FEAT_CB1: if (req.idx == 8'd0)    rd_word = 32'(cb1_sel);
      FEAT_PE:  if (req.idx == 8'd0)    rd_word = 32'({pe_oreg, pe_op});
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      config_rd_valid <= 1'b0;
      config_rd_data  <= '0;
    end else begin
      config_rd_valid <= req.rd;
      config_rd_data  <= req.rd ? rd_word : '0;
    end
  end

  logic [WIDTH-1:0] opa, opb, prod, alu, acc, pe_reg, pe_out;

  assign opa  = (int'(cb0_sel) < NW) ? in_w[cb0_sel] : '0;
  assign opb  = (int'(cb1_sel) < NW) ? in_w[cb1_sel] : '0;
  assign prod = opa * opb;

  // In MAC mode the result is the accumulator itself, so pe_reg tracks acc too.
  always_comb begin
    alu = '0;
    case (pe_op)
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      OP_AND:  alu = opa & opb;
      OP_OR:   alu = opa | opb;
      OP_XOR:  alu = opa ^ opb;
      OP_MUL:  alu = prod;
      OP_MAC:  alu = acc;
      OP_PASS: alu = opa;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      pe_reg <= '0;
    end else begin
      pe_reg <= alu;
      if (acc_clr)               acc <= '0;
      else if (pe_op == OP_MAC)  acc <= acc + prod;
    end
  end

  assign pe_out = (pe_oreg && pe_op != OP_MAC) ? pe_reg : alu;

  logic [NW-1:0][3:0][WIDTH-1:0] sb_src;
  always_comb begin
    sb_src = '0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        for (int k = 0; k < 3; k++)
          sb_src[s*NUM_TRACKS+t][k] = in_w[int'(sb_src_side(2'(s), 2'(k)))*NUM_TRACKS + t];
        sb_src[s*NUM_TRACKS+t][SB_SRC_PE] = pe_out;
      end
    end
  end

  for (genvar r = 0; r < NW; r++) begin : g_cell
    sb_track_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (clk),
      .reset  (reset),
      .src    (sb_src[r]),
      .sel    (sb_cfg[r][1:0]),
      .reg_en (sb_cfg[r][2]),
      .out    (out_w[r])
    );
  end

endmodule

// File: tb/tb_pe_tile_generic.sv
// Directed plus randomized bench for pe_tile_generic against a behavioural tile model.
module tb_pe_tile_generic;

  localparam int W  = 16;
  localparam int NT = 4;
  localparam int NW = 4 * NT;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       tile_id;
  logic [31:0]       config_addr, config_data, config_rd_data;
  logic              config_valid, config_read, config_rd_valid;
  logic [NW*W-1:0]   in_wires, out_wires;
  logic [NW-1:0][W-1:0] in_w, out_w;

  assign in_wires = in_w;
  assign out_w    = out_wires;

  always #5 clk = ~clk;

  pe_tile_generic #(.WIDTH(W), .NUM_TRACKS(NT)) dut (
    .clk             (clk),
    .reset           (reset),
    .tile_id         (tile_id),
    .config_addr     (config_addr),
    .config_data     (config_data),
    .config_valid    (config_valid),
    .config_read     (config_read),
    .config_rd_data  (config_rd_data),
    .config_rd_valid (config_rd_valid),
    .in_wires        (in_wires),
    .out_wires       (out_wires)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of the tile's architectural state
  logic [2:0]   m_sb  [NW];
  logic [W-1:0] m_sbq [NW];
  logic [3:0]   m_cb0, m_cb1;
  logic [2:0]   m_op;
  logic         m_oreg;
  logic [W-1:0] m_acc, m_pereg;
  logic [31:0]  m_rdd;
  logic         m_rdv;

  task automatic model_reset();
    for (int r = 0; r < NW; r++) begin m_sb[r] = 3'd0; m_sbq[r] = '0; end
    m_cb0 = 0; m_cb1 = 0; m_op = 0; m_oreg = 0; m_acc = 0; m_pereg = 0;
    m_rdd = 0; m_rdv = 0;
  endtask

  function automatic logic [W-1:0] m_alu();
    logic [W-1:0] a, b;
    logic [31:0]  p;
    a = in_w[m_cb0];
    b = in_w[m_cb1];
    p = a * b;
    case (m_op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return p[W-1:0];
      3'd6: return m_acc;
      default: return a;
    endcase
  endfunction

  function automatic logic [W-1:0] m_pe_out();
    return (m_oreg && m_op != 3'd6) ? m_pereg : m_alu();
  endfunction

  function automatic logic [W-1:0] m_src(input int r);
    int s, t, n;
    s = r / NT;
    t = r % NT;
    if (m_sb[r][1:0] == 2'd3) return m_pe_out();
    n = 0;
    for (int side = 0; side < 4; side++) begin
      if (side != s) begin
        if (n == int'(m_sb[r][1:0])) return in_w[side*NT + t];
        n++;
      end
    end
    return '0;
  endfunction

  function automatic logic [W-1:0] m_out(input int r);
    return m_sb[r][2] ? m_sbq[r] : m_src(r);
  endfunction

  function automatic logic [31:0] m_read(input int feat, input int idx);
    if (feat == 0 && idx < NW)  return 32'(m_sb[idx]);
    if (feat == 1 && idx == 0)  return 32'(m_cb0);
    if (feat == 2 && idx == 0)  return 32'(m_cb1);
    if (feat == 3 && idx == 0)  return 32'({m_oreg, m_op});
    return 32'd0;
  endfunction

  // Advance one clock: model next state from the values the DUT sees at the edge.
  task automatic tick();
    logic         hit, wr;
    int           feat, idx;
    logic [31:0]  data, p;
    logic [W-1:0] nq [NW];
    logic [W-1:0] npe, nacc;
    logic [31:0]  nrdd;
    logic         nrdv;
    hit  = config_valid && (config_addr[15:0] == tile_id);
    wr   = hit && !config_read;
    feat = int'(config_addr[23:16]);
    idx  = int'(config_addr[31:24]);
    data = config_data;
    for (int r = 0; r < NW; r++) nq[r] = m_src(r);
    npe = m_alu();
    p   = in_w[m_cb0] * in_w[m_cb1];
    if (wr && feat == 3 && idx == 1) nacc = '0;
    else if (m_op == 3'd6)           nacc = m_acc + p[W-1:0];
    else                             nacc = m_acc;
    nrdv = hit && config_read;
    nrdd = nrdv ? m_read(feat, idx) : 32'd0;
    @(posedge clk);
    #1;
    for (int r = 0; r < NW; r++) m_sbq[r] = nq[r];
    m_pereg = npe;
    m_acc   = nacc;
    m_rdv   = nrdv;
    m_rdd   = nrdd;
    if (wr) begin
      if (feat == 0 && idx < NW) m_sb[idx] = data[2:0];
      if (feat == 1 && idx == 0) m_cb0 = data[3:0];
      if (feat == 2 && idx == 0) m_cb1 = data[3:0];
      if (feat == 3 && idx == 0) begin m_op = data[2:0]; m_oreg = data[3]; end
    end
  endtask

  task automatic check_outs(input string tag);
    #1;
    for (int r = 0; r < NW; r++)
      chk($sformatf("%s_out%0d", tag, r), 32'(out_w[r]), 32'(m_out(r)));
    chk({tag, "_rdv"}, 32'(config_rd_valid), 32'(m_rdv));
    chk({tag, "_rdd"}, config_rd_data, m_rdd);
  endtask

  task automatic cmd(input logic [7:0] feat, input logic [7:0] idx, input logic [31:0] data,
                     input logic rd, input logic [15:0] tid);
    config_valid = 1'b1;
    config_read  = rd;
    config_addr  = {idx, feat, tid};
    config_data  = data;
    tick();
    config_valid = 1'b0;
    config_read  = 1'b0;
    config_addr  = '0;
    config_data  = '0;
    #1;
    chk("cmd_rdv", 32'(config_rd_valid), 32'(m_rdv));
    chk("cmd_rdd", config_rd_data, m_rdd);
  endtask

  task automatic rand_inputs();
    for (int r = 0; r < NW; r++) in_w[r] = W'($urandom);
  endtask

  initial begin
    logic [7:0]  rf, ri;
    logic [31:0] rdat;
    logic [15:0] rtid;
    logic        rrd;

    reset = 1'b0;
    tile_id = 16'd5;
    config_valid = 0; config_read = 0; config_addr = 0; config_data = 0;
    rand_inputs();
    model_reset();
    #12;
    chk("rst_rdv", 32'(config_rd_valid), 32'd0);
    chk("rst_rdd", config_rd_data, 32'd0);
    for (int t = 0; t < NT; t++) begin
      chk($sformatf("rst_s0_t%0d", t), 32'(out_w[t]), 32'(in_w[NT + t]));
      for (int s = 1; s < 4; s++)
        chk($sformatf("rst_s%0d_t%0d", s, t), 32'(out_w[s*NT + t]), 32'(in_w[t]));
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_outs("post_rst");

    // Registered PE route: side 0 track 1 <- PE (add, output registered)
    cmd(8'd0, 8'd1, 32'd3, 1'b0, 16'd5);
    cmd(8'd1, 8'd0, 32'd2, 1'b0, 16'd5);
    cmd(8'd2, 8'd0, 32'd3, 1'b0, 16'd5);
    cmd(8'd3, 8'd0, 32'd8, 1'b0, 16'd5);
    in_w[2] = 16'h0003;
    in_w[3] = 16'h0004;
    check_outs("pe_route0");
    tick();
    #1;
    chk("pe_route_sum", 32'(out_w[1]), 32'h0007);
    check_outs("pe_route1");

    // MAC with wrap, then +15/cycle, then clear
    in_w[2] = 16'h8000;
    in_w[3] = 16'h0002;
    cmd(8'd3, 8'd0, 32'd6, 1'b0, 16'd5);
    chk("mac_start", 32'(out_w[1]), 32'd0);
    tick(); #1; chk("mac_wrap1", 32'(out_w[1]), 32'd0);
    tick(); #1; chk("mac_wrap2", 32'(out_w[1]), 32'd0);
    in_w[2] = 16'd3;
    in_w[3] = 16'd5;
    tick(); #1; chk("mac_15", 32'(out_w[1]), 32'd15);
    tick(); #1; chk("mac_30", 32'(out_w[1]), 32'd30);
    check_outs("mac");
    cmd(8'd3, 8'd1, 32'd0, 1'b0, 16'd5);
    chk("mac_clear", 32'(out_w[1]), 32'd0);
    tick(); #1; chk("mac_after_clr", 32'(out_w[1]), 32'd15);

    // SB register: side 1 track 0 <- side 2 track 0, registered
    cmd(8'd0, 8'd4, 32'd5, 1'b0, 16'd5);
    in_w[8] = 16'hA5A5;
    check_outs("sbreg0");
    tick(); #1; chk("sbreg_lag1", 32'(out_w[4]), 32'hA5A5);
    in_w[8] = 16'h1234;
    #1; chk("sbreg_hold", 32'(out_w[4]), 32'hA5A5);
    tick(); #1; chk("sbreg_lag2", 32'(out_w[4]), 32'h1234);

    // Read-back and invalid access
    cmd(8'd1, 8'd0, 32'd0, 1'b1, 16'd5);
    chk("rd_cb0_data", config_rd_data, 32'd2);
    chk("rd_cb0_vld", 32'(config_rd_valid), 32'd1);
    tick(); #1;
    chk("rd_cb0_pulse", 32'(config_rd_valid), 32'd0);
    cmd(8'd1, 8'd0, 32'd0, 1'b1, 16'd6);
    chk("rd_miss_data", config_rd_data, 32'd0);
    chk("rd_miss_vld", 32'(config_rd_valid), 32'd0);
    cmd(8'd7, 8'd0, 32'hFFFF_FFFF, 1'b0, 16'd5);
    check_outs("feat7_wr");
    cmd(8'd7, 8'd0, 32'd0, 1'b1, 16'd5);
    chk("rd_feat7_data", config_rd_data, 32'd0);
    chk("rd_feat7_vld", 32'(config_rd_valid), 32'd1);
    cmd(8'd0, 8'd4, 32'd0, 1'b1, 16'd5);
    chk("rd_sb4", config_rd_data, 32'd5);
    cmd(8'd3, 8'd1, 32'd0, 1'b1, 16'd5);
    chk("rd_pe1_data", config_rd_data, 32'd0);
    chk("rd_pe1_vld", 32'(config_rd_valid), 32'd1);
    cmd(8'd0, 8'd16, 32'd0, 1'b1, 16'd5);
    chk("rd_sb16_data", config_rd_data, 32'd0);
    chk("rd_sb16_vld", 32'(config_rd_valid), 32'd1);
    cmd(8'd3, 8'd0, 32'd0, 1'b1, 16'd5);
    check_outs("rd_pe0");

    // Async reset between edges while accumulating
    cmd(8'd3, 8'd0, 32'd6, 1'b0, 16'd5);
    tick();
    tick();
    #1; chk("pre_rst_acc", 32'(out_w[1]), 32'(m_acc));
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_rdv", 32'(config_rd_valid), 32'd0);
    for (int r = 0; r < NW; r++)
      chk($sformatf("async_rst_out%0d", r), 32'(out_w[r]), 32'(m_out(r)));
    reset = 1'b1;
    cmd(8'd0, 8'd1, 32'd3, 1'b0, 16'd5);
    cmd(8'd3, 8'd0, 32'd6, 1'b0, 16'd5);
    chk("async_rst_acc0", 32'(out_w[1]), 32'd0);

    // Randomized traffic (MAC excluded so the model stays on plain opcodes)
    cmd(8'd3, 8'd0, 32'd0, 1'b0, 16'd5);
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      if ($urandom_range(0, 3) == 0) begin
        rf   = 8'($urandom_range(0, 5));
        ri   = (rf == 8'd0) ? 8'($urandom_range(0, 17)) : 8'($urandom_range(0, 2));
        rdat = $urandom;
        if (rf == 8'd3 && ri == 8'd0 && rdat[2:0] == 3'd6) rdat[2:0] = 3'd7;
        rrd  = 1'($urandom_range(0, 1));
        rtid = ($urandom_range(0, 7) == 0) ? 16'd6 : 16'd5;
        cmd(rf, ri, rdat, rrd, rtid);
      end else begin
        tick();
      end
      check_outs("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
